mio_bus_ctrl: RTL and testbench
===============================

Name: mio_bus_ctrl

Overview:
- Memory/IO bus controller directly upstream of the multi-cycle CPU control FSM.
- Accepts word-wide `MemRead`/`MemWrite` requests from the datapath and decodes the address to RAM or IO space.
- Runs the access with wait states or an ack handshake, then returns `rdata` and a one-cycle `MIO_ready` pulse.
- The control FSM stalls in IF (and in memory states) until `MIO_ready`.

Parameters:
- RAM_WAIT, 2, RAM wait-state cycles per access; legal range 1..15.
- IO_BASE, 4'hE, `addr[31:28]` value selecting IO space; every other value selects RAM.
- TIMEOUT_CYCLES, 255, IO cycles without ack before abort (used only with MIO_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  read request from the datapath.
- MemWrite  in  1  write request from the datapath.
- addr  in  32  byte address; bits [1:0] ignored.
- wdata  in  32  write data.
- MIO_ready  out  1  one-cycle pulse when the access is complete.
- rdata  out  32  read data, valid from the `MIO_ready` cycle and held until the next read completes.
- ram_addr  out  10  word address, equal to `addr[11:2]`.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  synchronous RAM read data.
- io_req  out  1  IO request, held until ack.
- io_we  out  1  IO write qualifier.
- io_addr  out  8  equal to `addr[9:2]`.
- io_wdata  out  32  IO write data.
- io_rdata  in  32  IO read data, valid with `io_ack`.
- io_ack  in  1  IO completion.
- bus_err  out  1  timeout flag, pulses with `MIO_ready`.

Behaviour:
- Reset (synchronous, active-high) gives state IDLE and drives all outputs to 0, including `rdata`. Reset asserted mid-access aborts it; `ram_we` and `io_req` drop at that edge and no `MIO_ready` is issued.
- States are IDLE, RAM_WAIT, IO_REQ and DONE.
- IDLE:
  - If `MemRead` or `MemWrite` is sampled high, latch `addr`, `wdata` and `we = MemWrite`.
  - Go to RAM_WAIT (loading wait counter = RAM_WAIT) or to IO_REQ, according to `addr[31:28]` versus IO_BASE.
  - With no request, stay in IDLE.
- Both `MemRead` and `MemWrite` high: treated as a write; `rdata` is unchanged.
- RAM_WAIT:
  - `ram_addr` and `ram_wdata` are driven from the latched registers.
  - `ram_we` is high only in the first RAM_WAIT cycle, and only for writes.
  - The counter decrements each cycle. At counter 1, go to DONE and capture `ram_rdata` into `rdata` if the access is a read.
- IO_REQ:
  - `io_req` is high with `io_we`, `io_addr` and `io_wdata` driven from the latched registers.
  - When `io_ack` is sampled high, capture `io_rdata` (reads only) and go to DONE.
  - `io_req` is low in the cycle after ack.
- DONE: `MIO_ready` = 1 for exactly this cycle; the next state is IDLE.
- Latency, with the request first sampled in cycle k:
  - RAM: `MIO_ready` in cycle k+RAM_WAIT+1.
  - IO: `MIO_ready` in cycle a+1, where a is the `io_ack` cycle (a ≥ k+1).
- Back-to-back: IDLE always lasts at least one cycle between accesses. A request still asserted in that IDLE cycle starts a new access, so the master must drop its request or change state.
- Inputs are ignored outside IDLE, and a request change mid-access has no effect.
- `io_ack` outside IO_REQ is ignored.

Optional Feature:
- Macro: MIO_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter counts IO_REQ cycles.
  - On reaching TIMEOUT_CYCLES without ack, go to DONE; `rdata` = 32'hDEADBEEF for reads (unchanged for writes) and `bus_err` = 1 in the `MIO_ready` cycle.
  - An ack in the same cycle as the timeout wins, and `bus_err` stays 0.
- Undefined: IO_REQ waits indefinitely and `bus_err` is tied to 0.

Decomposition:
- Package mio_pkg holds:
  - the state enum (IDLE, RAM_WAIT, IO_REQ, DONE);
  - localparam MIO_ERR_DATA = 32'hDEADBEEF;
  - the default IO_BASE.
- The address decode and wait counter are small enough to stay inline; no sub-module.

Test Plan:
- RAM read:
  - Stimulus: RAM_WAIT=2, `MemRead`=1, `addr`=32'h0000_0010, `ram_rdata`=32'h1234_5678.
  - Response: `ram_addr`=4 and `MIO_ready` pulses 3 cycles after sampling, with `rdata`=32'h1234_5678; `ram_we` stays 0.
- RAM write:
  - Stimulus: `MemWrite`=1, `addr`=32'h0000_0020, `wdata`=32'hCAFE0001.
  - Response: `ram_we` is high for exactly one cycle with `ram_addr`=8 and `ram_wdata`=32'hCAFE0001; `MIO_ready` follows at cycle +3; `rdata` is unchanged.
- IO read:
  - Stimulus: `addr`=32'hE000_0008, `io_ack` asserted 3 cycles after `io_req` rises, `io_rdata`=32'h0000_00AB.
  - Response: `io_addr`=2; `io_req` is held 4 cycles; `MIO_ready` pulses the cycle after ack with `rdata`=32'hAB.
- Simultaneous read and write:
  - Stimulus: `MemRead`=`MemWrite`=1 to RAM.
  - Response: a write is performed and `rdata` keeps its previous value.
- Reset mid-operation:
  - Stimulus: reset asserted during IO_REQ.
  - Response: `io_req`=0 and state IDLE at the next edge; no `MIO_ready`; `rdata`=0.
- Timeout (MIO_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: IO read with no ack.
  - Response: `MIO_ready` and `bus_err` pulse together with `rdata`=32'hDEADBEEF.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared types and constants for the memory/IO bus controller.
package mio_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RAM_WAIT = 2'd1,
    S_IO_REQ   = 2'd2,
    S_DONE     = 2'd3
  } mio_state_e;

  localparam logic [31:0] MIO_ERR_DATA    = 32'hDEADBEEF;
  localparam logic [3:0]  IO_BASE_DEFAULT = 4'hE;
  localparam int unsigned WAIT_W          = 4;

endpackage

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes RAM vs IO space, runs wait states or the
// io_ack handshake, returns rdata with a one-cycle MIO_ready. MIO_TIMEOUT_EN adds an IO timeout.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 2,
  parameter logic [3:0]  IO_BASE  = IO_BASE_DEFAULT
`ifdef MIO_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        MIO_ready,
  output logic [31:0] rdata,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ack,
  output logic        bus_err
);

  mio_state_e state_q, state_d;

  logic [WAIT_W-1:0] wait_q;
  logic [9:0]        addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              req_c;
  logic              start_c;
  logic              we_d;
  logic              tmo_hit_c;
  logic              unused_addr;

  assign req_c       = MemRead | MemWrite;
  assign start_c     = (state_q == S_IDLE) && req_c;
  assign we_d        = start_c ? MemWrite : we_q;
  assign unused_addr = ^{addr[27:12], addr[1:0]};

  assign ram_addr  = addr_q;
  assign io_addr   = addr_q[7:0];
  assign ram_wdata = wdata_q;
  assign io_wdata  = wdata_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_c) state_d = (addr[31:28] == IO_BASE) ? S_IO_REQ : S_RAM_WAIT;
      end
      S_RAM_WAIT: begin
        if (wait_q == WAIT_W'(1)) state_d = S_DONE;
      end
      S_IO_REQ: begin
        if (io_ack)         state_d = S_DONE;
        else if (tmo_hit_c) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latches, wait counter, read-data capture and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      wait_q    <= '0;
      rdata     <= '0;
      MIO_ready <= 1'b0;
      ram_we    <= 1'b0;
      io_req    <= 1'b0;
      io_we     <= 1'b0;
    end else begin
      MIO_ready <= (state_d == S_DONE);
      ram_we    <= start_c && (state_d == S_RAM_WAIT) && MemWrite;
      io_req    <= (state_d == S_IO_REQ);
      io_we     <= (state_d == S_IO_REQ) && we_d;

      if (start_c) begin
        addr_q  <= addr[11:2];
        wdata_q <= wdata;
        we_q    <= MemWrite;
        wait_q  <= WAIT_W'(RAM_WAIT);
      end else if (state_q == S_RAM_WAIT) begin
        wait_q  <= wait_q - WAIT_W'(1);
      end

      if (!we_q) begin
        if ((state_q == S_RAM_WAIT) && (wait_q == WAIT_W'(1))) rdata <= ram_rdata;
        else if ((state_q == S_IO_REQ) && io_ack)              rdata <= io_rdata;
        else if (tmo_hit_c)                                     rdata <= MIO_ERR_DATA;
      end
    end
  end

`ifdef MIO_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;

  // Ack in the same cycle as the timeout takes priority
  assign tmo_hit_c = (state_q == S_IO_REQ) && !io_ack && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q   <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= tmo_hit_c;
      if (state_q == S_IO_REQ) tmo_q <= tmo_q + TMO_W'(1);
      else                     tmo_q <= '0;
    end
  end
`else
  assign tmo_hit_c = 1'b0;
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: directed cases plus randomized accesses
// against a transaction-level latency/data model.
module tb_mio_bus_ctrl;

  localparam int unsigned RW = 2;
`ifdef MIO_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 1 << 30;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] addr, wdata;
  logic        MIO_ready;
  logic [31:0] rdata;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata, ram_rdata;
  logic        io_req, io_we;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic        io_ack;
  logic        bus_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rdata_model = '0;

  mio_bus_ctrl #(
    .RAM_WAIT(RW)
`ifdef MIO_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .MIO_ready(MIO_ready), .rdata(rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int step, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, obs, exp);
    end
  endtask

  // One access from IDLE; d = cycles from io_req rise to io_ack (IO only).
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] dat, input int d, input bit noise);
    bit          is_io, err;
    int          lat;
    logic [31:0] old_rd, new_rd;
    is_io  = (a[31:28] == 4'hE);
    err    = is_io && (d >= TMO);
    lat    = !is_io ? int'(RW) + 1 : (err ? TMO + 1 : d + 2);
    old_rd = rdata_model;
    if (!wr) rdata_model = err ? 32'hDEADBEEF : dat;
    new_rd = rdata_model;

    MemRead   = rd;
    MemWrite  = wr;
    addr      = a;
    wdata     = wd;
    ram_rdata = is_io ? ~dat : dat;
    io_rdata  = is_io ? dat : ~dat;
    io_ack    = 1'b0;

    for (int n = 1; n <= lat + 1; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("mio_ready", n, 32'(MIO_ready), 32'(n == lat));
      check("bus_err", n, 32'(bus_err), 32'(err && (n == lat)));
      check("rdata", n, rdata, (n >= lat) ? new_rd : old_rd);
      if (!is_io) begin
        check("ram_we", n, 32'(ram_we), 32'(wr && (n == 1)));
        check("io_req_idle", n, 32'(io_req), 32'(0));
        if (n <= int'(RW)) begin
          check("ram_addr", n, 32'(ram_addr), 32'(a[11:2]));
          check("ram_wdata", n, ram_wdata, wd);
        end
      end else begin
        check("io_req", n, 32'(io_req), 32'(n < lat));
        check("ram_we_io", n, 32'(ram_we), 32'(0));
        if (n < lat) begin
          check("io_we", n, 32'(io_we), 32'(wr));
          check("io_addr", n, 32'(io_addr), 32'(a[9:2]));
          check("io_wdata", n, io_wdata, wd);
        end
      end

      if (noise && (n < lat)) begin
        MemRead  = 1'($urandom);
        MemWrite = 1'($urandom);
        addr     = $urandom;
        wdata    = $urandom;
      end else begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
      end
      if (is_io) io_ack = (d < TMO) && (n == d + 1);
      else       io_ack = noise ? 1'($urandom) : 1'b0;
    end
    io_ack = 1'b0;
  endtask

  initial begin
    logic [3:0]  top;
    logic [31:0] ra;
    int          op;

    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
    ram_rdata = '0; io_rdata = '0; io_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mio_ready", 0, 32'(MIO_ready), 32'(0));
    check("rst_rdata", 0, rdata, 32'h0);
    check("rst_ram_we", 0, 32'(ram_we), 32'(0));
    check("rst_io_req", 0, 32'(io_req), 32'(0));
    check("rst_io_we", 0, 32'(io_we), 32'(0));
    check("rst_bus_err", 0, 32'(bus_err), 32'(0));
    check("rst_ram_addr", 0, 32'(ram_addr), 32'(0));
    check("rst_io_wdata", 0, io_wdata, 32'h0);
    reset = 1'b0;

    // Directed cases
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0001, 32'h5555_AAAA, 0, 1'b0);
    access(1'b1, 1'b0, 32'hE000_0008, 32'h0, 32'h0000_00AB, 3, 1'b0);
    access(1'b1, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 32'h7777_7777, 0, 1'b0);
    access(1'b0, 1'b1, 32'hE000_0100, 32'h0000_BEEF, 32'h1111_2222, 0, 1'b0);
    access(1'b1, 1'b0, 32'hF000_0FFC, 32'h0, 32'hA5A5_5A5A, 0, 1'b0);

    // Reset during IO_REQ aborts the access
    MemRead = 1'b1; addr = 32'hE000_0004;
    @(posedge clk); @(negedge clk);
    MemRead = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_io_req_before", 0, 32'(io_req), 32'(1));
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mid_io_req", 0, 32'(io_req), 32'(0));
    check("mid_mio_ready", 0, 32'(MIO_ready), 32'(0));
    check("mid_rdata", 0, rdata, 32'h0);
    check("mid_bus_err", 0, 32'(bus_err), 32'(0));
    rdata_model = '0;
    reset = 1'b0;
    io_ack = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); @(negedge clk);
      check("post_rst_ready", i, 32'(MIO_ready), 32'(0));
      check("post_rst_io_req", i, 32'(io_req), 32'(0));
    end
    io_ack = 1'b0;
    access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h0F0F_0F0F, 0, 1'b0);

`ifdef MIO_TIMEOUT_EN
    access(1'b1, 1'b0, 32'hE000_0010, 32'h0, 32'h0000_0001, 10, 1'b0);
    access(1'b1, 1'b0, 32'hE000_0014, 32'h0, 32'h0000_00C3, TMO - 1, 1'b0);
    access(1'b0, 1'b1, 32'hE000_0018, 32'h0000_1234, 32'h0, 10, 1'b0);
`endif

    // Randomized accesses with request noise mid-access
    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 2));
      top = 4'($urandom_range(0, 14));
      if (top == 4'hE) top = 4'hF;
      if ($urandom_range(0, 1) == 1) top = 4'hE;
      ra = {top, 28'($urandom)};
      access(op != 1, op != 0, ra, $urandom, $urandom, int'($urandom_range(0, 6)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
